// File: rtl/ultrasonic_ctrl_if.sv
// Sensor-side control/result bundle for ultrasonic_ctrl.
// slave: the controller's view; master: the driver/consumer's view.
interface ultrasonic_ctrl_if;
  logic        i_start;
  logic        i_echo;
  logic        o_trig;
  logic        o_busy;
  logic        o_valid;
  logic        o_timeout;
  logic [15:0] o_echo_us;
  logic [9:0]  o_dist_cm;

  modport slave (
    input  i_start, i_echo,
    output o_trig, o_busy, o_valid, o_timeout, o_echo_us, o_dist_cm
  );

  modport master (
    output i_start, i_echo,
    input  o_trig, o_busy, o_valid, o_timeout, o_echo_us, o_dist_cm
  );
endinterface

// File: rtl/ultrasonic_ctrl.sv
// HC-SR04-style measurement controller: trigger, echo width in us, width/CM_DIV in cm.
// Define ULTRASONIC_AUTO_REPEAT_EN to loop HOLDOFF back to TRIG for continuous measurement.
module ultrasonic_ctrl #(
  parameter int unsigned CLK_PER_US = 100,
  parameter int unsigned TRIG_US    = 10,
  parameter int unsigned TIMEOUT_US = 30000,
  parameter int unsigned HOLDOFF_US = 10000,
  parameter int unsigned CM_DIV     = 58
) (
  input  logic               clk,
  input  logic               rst,
  ultrasonic_ctrl_if.slave   bus
);

  localparam int unsigned PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_CALC,
    S_HOLDOFF
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_sync;
  logic [PW-1:0] r_presc;
  logic [15:0]   r_us;
  logic [15:0]   r_width;
  logic [15:0]   r_rem;
  logic [9:0]    r_quo;
  logic          r_valid;
  logic          r_timeout;
  logic [15:0]   r_echo_us;
  logic [9:0]    r_dist;

  logic          w_echo;
  logic          w_tick;
  logic          w_trig_hit;
  logic          w_tmo_hit;
  logic          w_hold_hit;
  logic          w_calc_done;
  logic          w_enter;
  logic          w_tmo_evt;
  logic          w_res_evt;
  logic [15:0]   w_width;

  assign w_echo      = r_sync[1];
  assign w_tick      = (r_presc == PW'(CLK_PER_US - 1));
  // "Reaches N" fires on the tick that would make the counter N, so each
  // timed phase lasts exactly N*CLK_PER_US cycles from state entry.
  assign w_trig_hit  = w_tick && (r_us == 16'(TRIG_US - 1));
  assign w_tmo_hit   = w_tick && (r_us == 16'(TIMEOUT_US - 1));
  assign w_hold_hit  = w_tick && (r_us == 16'(HOLDOFF_US - 1));
  assign w_calc_done = (r_rem < 16'(CM_DIV));
  // The detection cycle in WAIT_RISE also counts as high time, hence the
  // current-cycle tick is folded in to get whole microseconds.
  assign w_width     = r_us + 16'(w_tick);
  assign w_enter     = (w_state_nxt != r_state);

  always_comb begin
    w_state_nxt = r_state;
    w_tmo_evt   = 1'b0;
    w_res_evt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) w_state_nxt = S_TRIG;
      end
      S_TRIG: begin
        if (w_trig_hit) w_state_nxt = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
        if (w_echo) begin
          w_state_nxt = S_MEASURE;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_HOLDOFF;
          w_tmo_evt   = 1'b1;
        end
      end
      S_MEASURE: begin
        if (!w_echo) begin
          w_state_nxt = S_CALC;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_HOLDOFF;
          w_tmo_evt   = 1'b1;
        end
      end
      S_CALC: begin
        if (w_calc_done) begin
          w_state_nxt = S_HOLDOFF;
          w_res_evt   = 1'b1;
        end
      end
      S_HOLDOFF: begin
        if (w_hold_hit) begin
`ifdef ULTRASONIC_AUTO_REPEAT_EN
          w_state_nxt = S_TRIG;
`else
          w_state_nxt = S_IDLE;
`endif
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sync    <= '0;
      r_presc   <= '0;
      r_us      <= '0;
      r_width   <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_echo_us <= '0;
      r_dist    <= '0;
    end else begin
      r_sync  <= {r_sync[0], bus.i_echo};
      r_state <= w_state_nxt;
      r_valid <= w_tmo_evt | w_res_evt;

      if (w_enter) begin
        r_presc <= '0;
        r_us    <= '0;
      end else if (w_tick) begin
        r_presc <= '0;
        r_us    <= r_us + 16'd1;
      end else begin
        r_presc <= r_presc + PW'(1);
      end

      if (r_state == S_MEASURE && !w_echo) begin
        r_width <= w_width;
        r_rem   <= w_width;
        r_quo   <= '0;
      end else if (r_state == S_CALC && !w_calc_done) begin
        r_rem <= r_rem - 16'(CM_DIV);
        if (r_quo != '1) r_quo <= r_quo + 10'd1;
      end

      if (w_tmo_evt) begin
        r_echo_us <= 16'(TIMEOUT_US);
        r_dist    <= '1;
        r_timeout <= 1'b1;
      end else if (w_res_evt) begin
        r_echo_us <= r_width;
        r_dist    <= r_quo;
        r_timeout <= 1'b0;
      end
    end
  end

  assign bus.o_trig    = (r_state == S_TRIG);
  assign bus.o_busy    = (r_state != S_IDLE);
  assign bus.o_valid   = r_valid;
  assign bus.o_timeout = r_timeout;
  assign bus.o_echo_us = r_echo_us;
  assign bus.o_dist_cm = r_dist;

endmodule

// File: doc/ultrasonic_ctrl.md
# ultrasonic_ctrl

Measurement controller for the HC-SR04-style ultrasonic front end. It issues the trigger pulse, waits for the echo, measures echo width in microseconds, and converts that width to centimetres. It sits upstream of the timing/display logic and owns the sensor pins. Results go out with a one-cycle valid strobe. One measurement runs per start request, or continuously when auto-repeat is compiled in.

## Interface
- CLK_PER_US, 100, clock cycles per microsecond (100 MHz clk)
- TRIG_US, 10, trigger pulse width in µs
- TIMEOUT_US, 30000, max µs allowed in WAIT_RISE and in MEASURE
- HOLDOFF_US, 10000, dead time after each result before a new trigger
- CM_DIV, 58, µs-per-cm divisor

- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- i_start  in  1  single-cycle start request; sampled only in IDLE
- i_echo  in  1  asynchronous echo pin from sensor
- o_trig  out  1  trigger pin to sensor
- o_busy  out  1  high in every state except IDLE
- o_valid  out  1  one-cycle strobe; o_dist_cm / o_echo_us / o_timeout are valid on it
- o_timeout  out  1  result was a timeout (held with result)
- o_echo_us  out  16  measured echo width, µs, truncated
- o_dist_cm  out  10  distance in cm, truncated; 1023 on timeout

## Operation
- i_echo passes through a 2-flop synchronizer. Edges are detected on the synced signal.
- A prescaler counts 0..CLK_PER_US-1 and generates a 1-cycle us_tick on wrap. It clears on every state entry.
- A 16-bit us counter increments on us_tick and clears on every state entry.
- FSM states:
  - IDLE: i_start=1 → TRIG.
  - TRIG: o_trig=1. When us counter reaches TRIG_US → WAIT_RISE.
  - WAIT_RISE: synced echo=1 → MEASURE. If us counter reaches TIMEOUT_US → timeout result.
  - MEASURE: synced echo=0 → CALC with width = us counter. If us counter reaches TIMEOUT_US → timeout result.
  - CALC: divide by repeated subtraction, one subtract per cycle. Starts with remainder=width, quotient=0. While remainder ≥ CM_DIV: remainder -= CM_DIV, quotient++. When done, register the result, pulse o_valid → HOLDOFF.
  - HOLDOFF: when us counter reaches HOLDOFF_US → IDLE.
- Timeout result: o_echo_us=TIMEOUT_US, o_dist_cm=1023, o_timeout=1, o_valid pulse → HOLDOFF.
- Quotient saturates at 1023.
- Normal result clears o_timeout.
- i_start outside IDLE is ignored; there is no queueing.
- An echo already high in WAIT_RISE is taken as a rising condition (level, not edge). A sensor stuck high therefore measures, then times out in MEASURE.

## Timing
- Reset values:
  - FSM=IDLE
  - o_trig=0, o_busy=0, o_valid=0, o_timeout=0
  - o_echo_us=0, o_dist_cm=0
  - synchronizer, prescaler and counters all 0
- o_trig rises on the cycle after i_start is sampled. It stays high exactly TRIG_US×CLK_PER_US cycles.
- Echo detection latency is 2 cycles of synchronizer plus 1 FSM cycle.
- Measured width: full microseconds of synced-echo high time; partial µs is truncated.
- CALC latency is quotient+1 cycles. o_valid asserts on the last CALC cycle's next edge.
- o_valid is high exactly one cycle per measurement. Result outputs hold until the next o_valid or reset.
- rst at any point, including mid-TRIG, mid-MEASURE or mid-CALC:
  - next edge drops o_trig, returns to IDLE and clears all outputs;
  - no o_valid is issued.
- o_busy rises with o_trig and falls on entry to IDLE.

## Configuration
- ULTRASONIC_AUTO_REPEAT_EN defined:
  - HOLDOFF exits directly to TRIG, giving continuous measurement;
  - once started by i_start, the loop runs until rst;
  - o_busy stays high.
- Not defined: HOLDOFF → IDLE; each measurement needs i_start.

## Test plan
- Defaults, i_start pulse, echo held high 580 µs, 5 µs after trigger ends → o_trig high 1000 cycles; o_valid once; o_echo_us=580, o_dist_cm=10, o_timeout=0.
- Echo high 1175 µs → o_echo_us=1175, o_dist_cm=20 (truncated). Also echo high 57 µs → o_dist_cm=0.
- No echo after trigger → o_valid 30000 µs after WAIT_RISE entry, o_timeout=1, o_dist_cm=1023, o_echo_us=30000. o_busy stays high for HOLDOFF, then falls.
- i_start pulses during MEASURE and HOLDOFF → ignored. Exactly one o_valid; the next i_start after IDLE starts a fresh trigger.
- rst asserted mid-MEASURE → next cycle o_trig=0, o_busy=0, outputs 0, FSM=IDLE. Echo falling afterwards produces no o_valid.
- With ULTRASONIC_AUTO_REPEAT_EN and echo fixed at 1160 µs → successive o_trig rising edges spaced by a constant period. Every o_valid shows o_dist_cm=20. No i_start is needed after the first.
